// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state codes, default period lengths
// and the symbol-rate divisor helper.
package game_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_PRELIM = 3'd1;
    localparam state_t ST_GAME   = 3'd2;
    localparam state_t ST_ANSWER = 3'd3;
    localparam state_t ST_POST   = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    localparam int unsigned DEF_PRELIM_SEC = 3;
    localparam int unsigned DEF_GAME_SEC   = 20;
    localparam int unsigned DEF_ANSWER_SEC = 10;
    localparam int unsigned DEF_POST_SEC   = 3;
    localparam int unsigned DEF_MAX_LEVEL  = 8;
    localparam int unsigned DEF_BASE_DIV   = 100000000;
    localparam int unsigned DEF_DIV_STEP   = 5000000;

    // Higher levels shorten the symbol period by div_step cycles per level.
    function automatic logic [31:0] calc_divisor(input logic [31:0] base_div,
                                                 input logic [31:0] div_step,
                                                 input logic [3:0]  level);
        return base_div - (({28'd0, level}) - 32'd1) * div_step;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable divider: one-cycle Pulse every Divisor enabled cycles.
module tick_divider (
    input  logic        Clk100M,
    input  logic        RstN,
    input  logic        Enable,
    input  logic        Clear,
    input  logic [31:0] Divisor,
    output logic        Pulse
);

    logic [31:0] count;

    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            count <= 32'd0;
            Pulse <= 1'b0;
        end else if (Clear || !Enable) begin
            count <= 32'd0;
            Pulse <= 1'b0;
        end else if (count == Divisor - 32'd1) begin
            count <= 32'd0;
            Pulse <= 1'b1;
        end else begin
            count <= count + 32'd1;
            Pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game period sequencer: PRELIM/GAME/ANSWER/POST per level, 1 Hz countdown,
// level-scaled symbol tick during GAME.
//   state  | meaning
//   IDLE   | waiting for Start, outputs quiet
//   PRELIM | lead-in countdown
//   GAME   | symbols advance on SymGenTick
//   ANSWER | player answer window
//   POST   | wrap-up, then next level or DONE
//   DONE   | last level finished, Start restarts
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned PRELIM_SEC = DEF_PRELIM_SEC,
    parameter int unsigned GAME_SEC   = DEF_GAME_SEC,
    parameter int unsigned ANSWER_SEC = DEF_ANSWER_SEC,
    parameter int unsigned POST_SEC   = DEF_POST_SEC,
    parameter int unsigned MAX_LEVEL  = DEF_MAX_LEVEL,
    parameter int unsigned BASE_DIV   = DEF_BASE_DIV,
    parameter int unsigned DIV_STEP   = DEF_DIV_STEP
) (
    input  logic       Clk100M,
    input  logic       RstN,
    input  logic       Tick1Hz,
    input  logic       Start,
    input  logic       Abort,
    output logic       PrelimPeriod,
    output logic       GamePeriod,
    output logic       AnswerPeriod,
    output logic       PostPeriod,
    output logic       Done,
    output logic [3:0] Level,
    output logic [7:0] SecondsLeft,
    output logic       LevelChng,
    output logic       SymGenTick
);

    localparam logic [3:0] LVL_MAX    = 4'(MAX_LEVEL);
    localparam logic [7:0] PRELIM_DUR = 8'(PRELIM_SEC);
    localparam logic [7:0] GAME_DUR   = 8'(GAME_SEC);
    localparam logic [7:0] ANSWER_DUR = 8'(ANSWER_SEC);
    localparam logic [7:0] POST_DUR   = 8'(POST_SEC);

    state_t      state, state_nxt;
    logic [3:0]  level_nxt;
    logic [7:0]  secs_nxt;
    logic        chng_nxt;
    logic        div_enable, div_clear;
    logic [31:0] divisor;

    always_comb begin
        state_nxt = state;
        level_nxt = Level;
        secs_nxt  = SecondsLeft;
        chng_nxt  = 1'b0;
        if (Abort) begin
            state_nxt = ST_IDLE;
            level_nxt = 4'd1;
            secs_nxt  = 8'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        state_nxt = ST_PRELIM;
                        level_nxt = 4'd1;
                        secs_nxt  = PRELIM_DUR;
                    end
                end
                ST_PRELIM, ST_GAME, ST_ANSWER, ST_POST: begin
                    if (Tick1Hz) begin
                        if (SecondsLeft > 8'd1) begin
                            secs_nxt = SecondsLeft - 8'd1;
                        end else begin
                            case (state)
                                ST_PRELIM: begin
                                    state_nxt = ST_GAME;
                                    secs_nxt  = GAME_DUR;
                                end
                                ST_GAME: begin
                                    state_nxt = ST_ANSWER;
                                    secs_nxt  = ANSWER_DUR;
                                end
                                ST_ANSWER: begin
                                    state_nxt = ST_POST;
                                    secs_nxt  = POST_DUR;
                                end
                                default: begin
                                    if (Level < LVL_MAX) begin
                                        state_nxt = ST_PRELIM;
                                        level_nxt = Level + 4'd1;
                                        secs_nxt  = PRELIM_DUR;
                                        chng_nxt  = 1'b1;
                                    end else begin
                                        state_nxt = ST_DONE;
                                        secs_nxt  = 8'd0;
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    level_nxt = 4'd1;
                    secs_nxt  = 8'd0;
                end
            endcase
        end
    end

    // Flags are registered from the next state so they line up with state itself.
    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            state        <= ST_IDLE;
            Level        <= 4'd1;
            SecondsLeft  <= 8'd0;
            LevelChng    <= 1'b0;
            PrelimPeriod <= 1'b0;
            GamePeriod   <= 1'b0;
            AnswerPeriod <= 1'b0;
            PostPeriod   <= 1'b0;
            Done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            Level        <= level_nxt;
            SecondsLeft  <= secs_nxt;
            LevelChng    <= chng_nxt;
            PrelimPeriod <= (state_nxt == ST_PRELIM);
            GamePeriod   <= (state_nxt == ST_GAME);
            AnswerPeriod <= (state_nxt == ST_ANSWER);
            PostPeriod   <= (state_nxt == ST_POST);
            Done         <= (state_nxt == ST_DONE);
        end
    end

    // Enable only while staying in GAME so the exit cycle never carries a tick.
    assign div_clear  = (state_nxt == ST_GAME) && (state != ST_GAME);
    assign div_enable = (state == ST_GAME) && (state_nxt == ST_GAME);
    assign divisor    = calc_divisor(32'(BASE_DIV), 32'(DIV_STEP), Level);

    tick_divider u_tick_divider (
        .Clk100M (Clk100M),
        .RstN    (RstN),
        .Enable  (div_enable),
        .Clear   (div_clear),
        .Divisor (divisor),
        .Pulse   (SymGenTick)
    );

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with short periods and a fast divider.
module tb_game_sequencer;

    localparam int SEC  = 2;
    localparam int BASE = 20;
    localparam int STEP = 4;
    localparam int MAXL = 2;

    logic       Clk100M = 1'b0;
    logic       RstN    = 1'b1;
    logic       Tick1Hz = 1'b0;
    logic       Start   = 1'b0;
    logic       Abort   = 1'b0;
    logic       PrelimPeriod, GamePeriod, AnswerPeriod, PostPeriod, Done;
    logic [3:0] Level;
    logic [7:0] SecondsLeft;
    logic       LevelChng, SymGenTick;

    game_sequencer #(
        .PRELIM_SEC (SEC), .GAME_SEC (SEC), .ANSWER_SEC (SEC), .POST_SEC (SEC),
        .MAX_LEVEL (MAXL), .BASE_DIV (BASE), .DIV_STEP (STEP)
    ) dut (
        .Clk100M      (Clk100M),
        .RstN         (RstN),
        .Tick1Hz      (Tick1Hz),
        .Start        (Start),
        .Abort        (Abort),
        .PrelimPeriod (PrelimPeriod),
        .GamePeriod   (GamePeriod),
        .AnswerPeriod (AnswerPeriod),
        .PostPeriod   (PostPeriod),
        .Done         (Done),
        .Level        (Level),
        .SecondsLeft  (SecondsLeft),
        .LevelChng    (LevelChng),
        .SymGenTick   (SymGenTick)
    );

    always #5 Clk100M = ~Clk100M;

    int n_vec = 0;
    int n_err = 0;

    // Reference: phase 0=idle, 1..4 = prelim/game/answer/post, 5 = done.
    int   m_phase, m_level, m_secs, m_gcyc;
    logic m_chng, m_sym;
    int   durs[5] = '{0, SEC, SEC, SEC, SEC};

    localparam logic [18:0] IDLE_VEC = {5'b00000, 4'd1, 8'd0, 1'b0, 1'b0};

    function automatic logic [18:0] exp_vec();
        return {m_phase == 1, m_phase == 2, m_phase == 3, m_phase == 4, m_phase == 5,
                4'(m_level), 8'(m_secs), m_chng, m_sym};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {PrelimPeriod, GamePeriod, AnswerPeriod, PostPeriod, Done,
                Level, SecondsLeft, LevelChng, SymGenTick};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_level = 1; m_secs = 0; m_gcyc = 0; m_chng = 1'b0; m_sym = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic t);
        int prev;
        prev   = m_phase;
        m_chng = 1'b0;
        if (a) begin
            m_phase = 0; m_level = 1; m_secs = 0;
        end else if (m_phase == 0 || m_phase == 5) begin
            if (s) begin m_phase = 1; m_level = 1; m_secs = durs[1]; end
        end else if (t) begin
            if (m_secs > 1) m_secs = m_secs - 1;
            else if (m_phase < 4) begin m_phase = m_phase + 1; m_secs = durs[m_phase]; end
            else if (m_level < MAXL) begin
                m_phase = 1; m_level = m_level + 1; m_secs = durs[1]; m_chng = 1'b1;
            end else begin
                m_phase = 5; m_secs = 0;
            end
        end
        if (m_phase == 2 && prev == 2) begin
            m_gcyc = m_gcyc + 1;
            m_sym  = (m_gcyc % (BASE - (m_level - 1) * STEP)) == 0;
        end else begin
            m_gcyc = 0;
            m_sym  = 1'b0;
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic t);
        @(negedge Clk100M);
        Start = s; Abort = a; Tick1Hz = t;
        @(posedge Clk100M);
        #1;
        Start = 1'b0; Abort = 1'b0; Tick1Hz = 1'b0;
        model_step(s, a, t);
    endtask

    task automatic goto_game();
        drive(0, 1, 0);
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 1);
        n_vec++;
        if (obs_vec() !== exp_vec() || GamePeriod !== 1'b1) begin
            n_err++;
            $display("FAIL goto_game: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset();
        #1 RstN = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs_vec() !== IDLE_VEC) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), IDLE_VEC);
        end
        repeat (2) @(posedge Clk100M);
        @(negedge Clk100M) RstN = 1'b1;
    endtask

    task automatic test_periods();
        int exp_ph[4]   = '{1, 2, 2, 3};
        int exp_secs[4] = '{1, 2, 1, 2};
        drive(0, 1, 0);
        drive(1, 0, 0);
        n_vec++;
        if (PrelimPeriod !== 1'b1 || SecondsLeft !== 8'd2 || Level !== 4'd1) begin
            n_err++;
            $display("FAIL period_start: got prelim=%b secs=%0d lvl=%0d want 1/2/1",
                     PrelimPeriod, SecondsLeft, Level);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0);
            drive(0, 0, 1);
            n_vec++;
            if ({PrelimPeriod, GamePeriod, AnswerPeriod} !== 3'(4 >> (exp_ph[i] - 1))
                || SecondsLeft !== 8'(exp_secs[i]) || obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL period_tick%0d: got %h want phase %0d secs %0d",
                         i, obs_vec(), exp_ph[i], exp_secs[i]);
            end
        end
    endtask

    task automatic test_symgen();
        goto_game();
        for (int k = 1; k <= 45; k++) begin
            drive(0, 0, 0);
            n_vec++;
            if (SymGenTick !== (k == 20 || k == 40) || obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL symgen_l1 k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 8; i++) drive(0, 0, 1);
        n_vec++;
        if (GamePeriod !== 1'b1 || Level !== 4'd2) begin
            n_err++;
            $display("FAIL symgen_l2_entry: got game=%b lvl=%0d want 1/2", GamePeriod, Level);
        end
        for (int k = 1; k <= 40; k++) begin
            drive(0, 0, 0);
            n_vec++;
            if (SymGenTick !== (k == 16 || k == 32) || obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL symgen_l2 k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_level_up();
        goto_game();
        for (int i = 0; i < 6; i++) drive(0, 0, 1);
        n_vec++;
        if (LevelChng !== 1'b1 || Level !== 4'd2 || PrelimPeriod !== 1'b1 || SecondsLeft !== 8'd2) begin
            n_err++;
            $display("FAIL level_up: got chng=%b lvl=%0d prelim=%b secs=%0d want 1/2/1/2",
                     LevelChng, Level, PrelimPeriod, SecondsLeft);
        end
        drive(0, 0, 0);
        n_vec++;
        if (LevelChng !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL level_chng_width: got chng=%b want 0", LevelChng);
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL level2_run%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (Done !== 1'b1 || LevelChng !== 1'b0 || SecondsLeft !== 8'd0 || Level !== 4'd2) begin
            n_err++;
            $display("FAIL final_done: got done=%b chng=%b secs=%0d lvl=%0d want 1/0/0/2",
                     Done, LevelChng, SecondsLeft, Level);
        end
    endtask

    task automatic test_abort();
        goto_game();
        repeat (19) drive(0, 0, 0);
        drive(0, 1, 1);
        n_vec++;
        if (obs_vec() !== IDLE_VEC || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL abort_tick: got %h want %h", obs_vec(), IDLE_VEC);
        end
    endtask

    task automatic test_reset_mid();
        goto_game();
        repeat (5) drive(0, 0, 0);
        @(negedge Clk100M);
        #2 RstN = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs_vec() !== IDLE_VEC) begin
            n_err++;
            $display("FAIL reset_async: got %h want %h", obs_vec(), IDLE_VEC);
        end
        repeat (3) @(posedge Clk100M);
        @(negedge Clk100M) RstN = 1'b1;
        drive(0, 0, 1);
        n_vec++;
        if (obs_vec() !== IDLE_VEC || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_release_tick: got %h want %h", obs_vec(), IDLE_VEC);
        end
    endtask

    task automatic test_start_ignored();
        goto_game();
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(1, 0, 0);
        n_vec++;
        if (AnswerPeriod !== 1'b1 || SecondsLeft !== 8'd2 || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL start_in_answer: got %h want %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 12; i++) drive(0, 0, 1);
        n_vec++;
        if (Done !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reach_done: got %h want %h", obs_vec(), exp_vec());
        end
        drive(1, 0, 0);
        n_vec++;
        if (PrelimPeriod !== 1'b1 || Level !== 4'd1 || SecondsLeft !== 8'd2 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_done: got %h want prelim lvl1 secs2", obs_vec());
        end
    endtask

    task automatic test_random();
        int tick_pct;
        logic s, a, t;
        for (int seg = 0; seg < 6; seg++) begin
            tick_pct = (seg % 2 == 0) ? 3 : 35;
            for (int i = 0; i < 150; i++) begin
                a = ($urandom_range(0, 99) < 2);
                s = ($urandom_range(0, 99) < 6);
                t = ($urandom_range(0, 99) < tick_pct);
                drive(s, a, t);
                n_vec++;
                if (obs_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL random seg%0d i%0d: got %h want %h", seg, i, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_periods();
        test_symgen();
        test_level_up();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  PRELIM_SEC, 3, seconds in prelim period
  GAME_SEC, 20, seconds in game period
  ANSWER_SEC, 10, seconds in answer period
  POST_SEC, 3, seconds in post period
  MAX_LEVEL, 8, last level
  BASE_DIV, 100000000, Clk100M cycles per SymGenTick at level 1
  DIV_STEP, 5000000, cycles removed per level above 1
REQ-002 Ports SHALL be, one per line: name direction width meaning.
  Clk100M input 1 sole clock, 100 MHz
  RstN input 1 reset, asynchronous, active-low
  Tick1Hz input 1 one-cycle pulse once per second
  Start input 1 one-cycle start pulse
  Abort input 1 one-cycle abort pulse
  PrelimPeriod output 1 high while in PRELIM
  GamePeriod output 1 high while in GAME
  AnswerPeriod output 1 high while in ANSWER
  PostPeriod output 1 high while in POST
  Done output 1 high while in DONE
  Level output 4 current level, 1..MAX_LEVEL
  SecondsLeft output 8 seconds remaining in current period
  LevelChng output 1 one-cycle pulse on level increment
  SymGenTick output 1 one-cycle symbol-advance pulse

Function
REQ-003 States SHALL be IDLE, PRELIM, GAME, ANSWER, POST, DONE; all outputs registered, changing the cycle after the triggering input is sampled.
REQ-004 IDLE or DONE with Start=1 SHALL go to PRELIM, Level=1, SecondsLeft=PRELIM_SEC.
REQ-005 In PRELIM/GAME/ANSWER/POST, Tick1Hz=1 with SecondsLeft>1 SHALL decrement SecondsLeft by 1.
REQ-006 Tick1Hz=1 with SecondsLeft==1 SHALL advance PRELIM->GAME->ANSWER->POST, loading the next period's duration.
REQ-007 At POST expiry: Level<MAX_LEVEL SHALL give PRELIM, Level+1, SecondsLeft=PRELIM_SEC, LevelChng=1 for one cycle; Level==MAX_LEVEL SHALL give DONE, SecondsLeft=0.
REQ-008 Abort=1 in any state SHALL force IDLE, Level=1, SecondsLeft=0, SymGenTick=0; Abort takes priority over Start and Tick1Hz in the same cycle.
REQ-009 Start outside IDLE/DONE SHALL be ignored; Tick1Hz in IDLE/DONE SHALL be ignored.
REQ-010 Divisor SHALL be BASE_DIV-(Level-1)*DIV_STEP, computed 32-bit unsigned; parameters SHALL satisfy BASE_DIV>(MAX_LEVEL-1)*DIV_STEP.
REQ-011 Divider counter SHALL clear on every entry to GAME and hold 0 outside GAME.
REQ-012 In GAME, SymGenTick SHALL pulse one cycle when counter==divisor-1, counter wrapping to 0; first pulse exactly divisor cycles after GAME entry.
REQ-013 SymGenTick SHALL be 0 in all states except GAME, including the GAME exit cycle.
REQ-014 Exactly one of the five state flags SHALL be high in non-IDLE states; all low in IDLE.

Reset
REQ-015 RstN=0 SHALL asynchronously force IDLE, Level=1, SecondsLeft=0, divider counter 0, all 1-bit outputs 0.
REQ-016 Reset release mid-period SHALL resume from IDLE; no stale LevelChng or SymGenTick.

Structure
REQ-017 State enum, period-duration defaults and divider defaults SHALL live in shared package game_pkg.
REQ-018 Programmable divider SHALL be sub-module tick_divider (inputs Enable, Clear, Divisor[31:0]; output Pulse).

Verification (bench overrides: BASE_DIV=20, DIV_STEP=4, MAX_LEVEL=2, all *_SEC=2)
REQ-019 Start then four Tick1Hz -> PRELIM SecondsLeft 2->1, GAME SecondsLeft=2, then 1, ANSWER SecondsLeft=2.
REQ-020 GAME at Level 1 held 45 cycles without tick -> SymGenTick at cycles 20 and 40 after GAME entry; Level 2 -> every 16 cycles.
REQ-021 Run level 1 to POST expiry -> LevelChng one cycle, Level=2, PRELIM; POST expiry at Level 2 -> Done=1, no LevelChng.
REQ-022 Abort coincident with Tick1Hz in GAME -> IDLE, Level=1, SecondsLeft=0, no SymGenTick.
REQ-023 RstN low 3 cycles mid-GAME -> all outputs 0, Level=1 immediately; Tick1Hz after release -> stays IDLE.
REQ-024 Start during ANSWER -> ignored; Start in DONE -> PRELIM, Level=1.
